fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle control unit.
- Owns the PC register and a multi-cycle handshake to instruction memory.
- Latches the fetched word and presents op/funct3/funct7_5 to the control unit.
- Consumes the control unit's PCSrc plus the datapath's branch/jump target to select the next PC.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/pc_register.sv | 37 +++
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage and its neighbours: opcode
// constants, the reset NOP encoding and the fetch FSM state type.
package riscv_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   // addi x0,x0,0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_FAULT
   } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter: async reset to RESET_PC, loads either PC+4 or the
// word-aligned branch/jump target when i_load is asserted.
module pc_register #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_load,
   input  logic            i_pc_src,
   input  logic [XLEN-1:0] i_pc_target,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_pc_plus4
);

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_next;
   logic [1:0]      w_unused_tgt_lo;

   // Target low bits are discarded: misaligned targets are silently masked.
   assign w_unused_tgt_lo = i_pc_target[1:0];
   assign o_pc_plus4      = r_pc + XLEN'(4);
   assign o_pc            = r_pc;

   // Next-PC select: sequential or aligned target.
   always_comb begin
      w_pc_next = o_pc_plus4;
      if (i_pc_src) w_pc_next = {i_pc_target[XLEN-1:2], 2'b00};
   end

   // PC register with load enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_pc <= RESET_PC;
      else if (i_load) r_pc <= w_pc_next;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the IDLE/FETCH/EXEC handshake
// with instruction memory and presents the latched instruction fields to
// the control unit.
// Optional macro FETCH_TIMEOUT_EN adds a FETCH-wait watchdog that parks the
// FSM in a sticky FAULT state after TIMEOUT_CYCLES cycles without imem_valid.
module fetch_unit #(
   parameter int unsigned     XLEN           = 32,
   parameter logic [XLEN-1:0] RESET_PC       = '0,
   parameter int unsigned     TIMEOUT_CYCLES = 16
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            imem_valid,
   input  logic            PCSrc,
   input  logic [XLEN-1:0] PCTarget,
   input  logic            exec_done,
   output logic [XLEN-1:0] Instr,
   output logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] PCPlus4,
   output logic            instr_valid,
   output logic [6:0]      op,
   output logic [2:0]      funct3,
   output logic            funct7_5,
   output logic            fetch_fault
);

   import riscv_pkg::*;

   fetch_state_t    r_state;
   fetch_state_t    w_next_state;
   logic [XLEN-1:0] r_instr;
   logic            r_instr_valid;
   logic            w_capture;
   logic            w_pc_load;

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_wait_cnt;
   logic             w_timeout;

   assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Wait counter: zero outside FETCH, counts FETCH cycles without a response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                   r_wait_cnt <= '0;
      else if (r_state != ST_FETCH) r_wait_cnt <= '0;
      else if (!imem_valid)        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
   end

   assign fetch_fault = (r_state == ST_FAULT);
`else
   assign fetch_fault = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state and handshake decode; exec_done takes precedence in EXEC.
   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      w_pc_load    = 1'b0;
      case (r_state)
         ST_IDLE:  w_next_state = ST_FETCH;
         ST_FETCH: begin
            if (imem_valid) begin
               w_capture    = 1'b1;
               w_next_state = ST_EXEC;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (w_timeout) begin
               w_next_state = ST_FAULT;
            end
`endif
         end
         ST_EXEC: begin
            if (exec_done) begin
               w_pc_load    = 1'b1;
               w_next_state = ST_FETCH;
            end
         end
         default:  w_next_state = r_state;
      endcase
   end

   // Instruction latch and its valid flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_instr       <= XLEN'(NOP_INSTR);
         r_instr_valid <= 1'b0;
      end else begin
         if (w_capture) r_instr <= imem_rdata;
         r_instr_valid <= (w_next_state == ST_EXEC);
      end
   end

   pc_register #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_pc_load),
      .i_pc_src    (PCSrc),
      .i_pc_target (PCTarget),
      .o_pc        (PC),
      .o_pc_plus4  (PCPlus4)
   );

   assign imem_req    = (r_state == ST_FETCH);
   assign imem_addr   = PC;
   assign Instr       = r_instr;
   assign instr_valid = r_instr_valid;
   assign op          = r_instr[6:0];
   assign funct3      = r_instr[14:12];
   assign funct7_5    = r_instr[30];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized handshakes,
// checked every cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;

   import riscv_pkg::*;

   localparam int unsigned TMO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic        PCSrc;
   logic [31:0] PCTarget;
   logic        exec_done;
   logic [31:0] Instr;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        instr_valid;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7_5;
   logic        fetch_fault;

   int n_checks = 0;
   int n_errors = 0;

   fetch_unit #(
      .XLEN           (32),
      .RESET_PC       (32'h0000_0000),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_valid  (imem_valid),
      .PCSrc       (PCSrc),
      .PCTarget    (PCTarget),
      .exec_done   (exec_done),
      .Instr       (Instr),
      .PC          (PC),
      .PCPlus4     (PCPlus4),
      .instr_valid (instr_valid),
      .op          (op),
      .funct3      (funct3),
      .funct7_5    (funct7_5),
      .fetch_fault (fetch_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_started: one cycle has elapsed since reset (request begins)
   // m_req: a fetch is outstanding; m_valid: an instruction is held
   logic [31:0] m_pc    = 32'h0;
   logic [31:0] m_instr = 32'h0000_0013;
   bit          m_started = 0, m_req = 0, m_valid = 0, m_fault = 0;
   int          m_wait = 0;

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_pc = 32'h0; m_instr = 32'h0000_0013;
            m_started = 0; m_req = 0; m_valid = 0; m_fault = 0; m_wait = 0;
         end else if (!m_started) begin
            m_started = 1; m_req = 1; m_wait = 0;
         end else if (m_fault) begin
            // parked until reset
         end else if (m_req) begin
            if (imem_valid) begin
               m_instr = imem_rdata; m_valid = 1; m_req = 0;
            end
`ifdef FETCH_TIMEOUT_EN
            else begin
               m_wait++;
               if (m_wait == TMO) begin m_fault = 1; m_req = 0; end
            end
`endif
         end else if (m_valid && exec_done) begin
            m_pc    = PCSrc ? (PCTarget & 32'hFFFF_FFFC) : m_pc + 32'd4;
            m_valid = 0; m_req = 1; m_wait = 0;
         end
      end
   end

   // Compare process: every cycle, all outputs against the model.
   initial begin
      #20;
      forever begin
         @(negedge clk);
         chk("imem_req",    {31'b0, imem_req},    {31'b0, m_req});
         chk("imem_addr",   imem_addr,            m_pc);
         chk("PC",          PC,                   m_pc);
         chk("PCPlus4",     PCPlus4,              m_pc + 32'd4);
         chk("Instr",       Instr,                m_instr);
         chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
         chk("op",          {25'b0, op},          {25'b0, m_instr[6:0]});
         chk("funct3",      {29'b0, funct3},      {29'b0, m_instr[14:12]});
         chk("funct7_5",    {31'b0, funct7_5},    {31'b0, m_instr[30]});
         chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1; imem_valid = 0; imem_rdata = '0;
      PCSrc = 0; PCTarget = '0; exec_done = 0;
      tick(); tick();
      chk("rst_pc",    PC,                   32'h0);
      chk("rst_instr", Instr,                32'h0000_0013);
      chk("rst_valid", {31'b0, instr_valid}, 32'h0);
      chk("rst_req",   {31'b0, imem_req},    32'h0);
      reset = 1'b0;

      // first fetch: request one cycle after release, 1-cycle memory
      tick();
      chk("first_req",  {31'b0, imem_req}, 32'h1);
      chk("first_addr", imem_addr,         32'h0);
      imem_valid = 1; imem_rdata = 32'h0000_2003;
      tick();
      imem_valid = 0;
      chk("first_valid", {31'b0, instr_valid}, 32'h1);
      chk("first_op",    {25'b0, op},          {25'b0, OP_LW});
      exec_done = 1; PCSrc = 0;
      tick();
      exec_done = 0;
      chk("seq_addr", imem_addr, 32'h4);

      // capture, then stray imem_valid in EXEC, then exec_done+valid together
      imem_valid = 1; imem_rdata = 32'h0050_0093;
      tick();
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_valid = 0;
      chk("exec_hold", Instr, 32'h0050_0093);
      imem_valid = 1; exec_done = 1; PCSrc = 1; PCTarget = 32'h0000_0102;
      tick();
      imem_valid = 0; PCSrc = 0;
      chk("tgt_addr", imem_addr, 32'h0000_0100);
      repeat (3) tick();   // exec_done still high during FETCH: ignored
      exec_done = 0;
      chk("fetch_hold", imem_addr, 32'h0000_0100);
      chk("fetch_req",  {31'b0, imem_req}, 32'h1);

      // wrap-around at the top of the address space
      imem_valid = 1; imem_rdata = 32'h4000_5033;
      tick();
      imem_valid = 0;
      chk("sub_f75", {31'b0, funct7_5}, 32'h1);
      exec_done = 1; PCSrc = 1; PCTarget = 32'hFFFF_FFFF;
      tick();
      exec_done = 0; PCSrc = 0;
      chk("top_addr", imem_addr, 32'hFFFF_FFFC);
      chk("top_p4",   PCPlus4,   32'h0);
      imem_valid = 1; imem_rdata = 32'h0000_0013;
      tick();
      imem_valid = 0; exec_done = 1;
      tick();
      exec_done = 0;
      chk("wrap_addr", imem_addr, 32'h0);

      // reset two cycles into a slow fetch; late response ignored
      tick(); tick();
      reset = 1;
      #1;
      chk("mid_pc",    PC,                   32'h0);
      chk("mid_valid", {31'b0, instr_valid}, 32'h0);
      chk("mid_instr", Instr,                32'h0000_0013);
      imem_valid = 1; imem_rdata = 32'h1234_5678;
      tick();
      reset = 0;
      tick();
      imem_valid = 0;
      chk("late_valid", {31'b0, instr_valid}, 32'h0);
      chk("late_instr", Instr,                32'h0000_0013);

      // long wait in FETCH
      repeat (TMO + 4) tick();
`ifdef FETCH_TIMEOUT_EN
      chk("tmo_fault", {31'b0, fetch_fault}, 32'h1);
      chk("tmo_req",   {31'b0, imem_req},    32'h0);
      reset = 1; tick(); reset = 0; tick();
      repeat (TMO - 1) tick();
      imem_valid = 1; imem_rdata = 32'h0000_0013;
      tick();
      imem_valid = 0;
      chk("edge_fault", {31'b0, fetch_fault}, 32'h0);
      chk("edge_valid", {31'b0, instr_valid}, 32'h1);
`else
      chk("wait_req",   {31'b0, imem_req},    32'h1);
      chk("wait_fault", {31'b0, fetch_fault}, 32'h0);
`endif

      // randomized handshakes with occasional reset
      for (int i = 0; i < 3000; i++) begin
         imem_valid = ($urandom_range(0, 2) == 0);
         imem_rdata = $urandom;
         exec_done  = ($urandom_range(0, 2) == 0);
         PCSrc      = $urandom_range(0, 1) == 1;
         PCTarget   = $urandom;
         if ($urandom_range(0, 99) == 0) reset = 1;
         tick();
         reset = 0;
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
